// File: rtl/audio_pkg.sv
// Shared audio types: one signed 32-bit sample and a left/right stereo pair.
// Effect stages downstream import the same types so pairs pass between
// blocks without repacking.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 32;
    localparam int unsigned OVR_W    = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

endpackage

// File: rtl/audio_in_buffer_if.sv
// Bus bundle between the codec input buffer and its neighbours.
//   slave  : the buffer side (takes the codec pair, flush and ready; drives the
//            read strobe, the FIFO head, fill level and overrun count)
//   master : the environment side (codec + downstream consumer)
interface audio_in_buffer_if #(
    parameter int unsigned DEPTH = 8
);
    import audio_pkg::*;

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic              audio_in_available;
    sample_t           audio_in_L;
    sample_t           audio_in_R;
    logic              read_audio_in;
    logic              flush;
    logic              sample_valid;
    logic              sample_ready;
    sample_t           sample_L;
    sample_t           sample_R;
    logic [CW-1:0]     fill_level;
    logic [OVR_W-1:0]  overrun_cnt;

    modport slave (
        input  audio_in_available, audio_in_L, audio_in_R, flush, sample_ready,
        output read_audio_in, sample_valid, sample_L, sample_R, fill_level, overrun_cnt
    );

    modport master (
        output audio_in_available, audio_in_L, audio_in_R, flush, sample_ready,
        input  read_audio_in, sample_valid, sample_L, sample_R, fill_level, overrun_cnt
    );

endinterface

// File: rtl/stereo_fifo_mem.sv
// DEPTH x stereo pair storage: one synchronous write port, one asynchronous
// read port. Not reset; the owning FIFO's pointers decide which entries count.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : pair to store
//   raddr : read address
//   rdata : pair at raddr (combinational)
module stereo_fifo_mem
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(DEPTH)-1:0]    waddr,
    input  stereo_t                     wdata,
    input  logic [$clog2(DEPTH)-1:0]    raddr,
    output stereo_t                     rdata
);

    stereo_t mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // First-word-fall-through read
    assign rdata = mem_q[raddr];

endmodule

// File: rtl/audio_in_buffer.sv
// Codec input buffer: pulls stereo pairs from the audio codec with a one-cycle
// read strobe and presents them downstream through a valid/ready FIFO.
//   CLOCK_50 : sole clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of audio_in_buffer_if
//              in : audio_in_available, audio_in_L/R, flush, sample_ready
//              out: read_audio_in, sample_valid, sample_L/R, fill_level, overrun_cnt
module audio_in_buffer
    import audio_pkg::*;
#(
    parameter int unsigned  DEPTH   = 8,
    parameter logic [15:0]  SAT_MAX = 16'hFFFF
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    audio_in_buffer_if.slave    bus
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             rd_strobe_q;
    logic             valid_q;
    logic [OVR_W-1:0] ovr_q;

    logic             full_c, write_c, read_c, blocked_c;
    logic [CW-1:0]    count_nxt_c;
    logic [OVR_W-1:0] ovr_nxt_c;
    stereo_t          wdata_c, head_c;

    // Write/read qualification, next count and overrun counter
    always_comb begin
        full_c      = 1'b0;
        write_c     = 1'b0;
        read_c      = 1'b0;
        blocked_c   = 1'b0;
        count_nxt_c = count_q;
        ovr_nxt_c   = ovr_q;
        wdata_c     = '{l: bus.audio_in_L, r: bus.audio_in_R};

        full_c    = (count_q == CW'(DEPTH));
        // A pending strobe means the codec has not yet retired this pair,
        // so the cycle right after a write is never eligible.
        write_c   = bus.audio_in_available & ~rd_strobe_q & ~full_c & ~bus.flush;
        blocked_c = bus.audio_in_available & ~rd_strobe_q &  full_c & ~bus.flush;
        read_c    = valid_q & bus.sample_ready & ~bus.flush;

        if (bus.flush) begin
            count_nxt_c = '0;
        end else if (write_c && !read_c) begin
            count_nxt_c = count_q + CW'(1);
        end else if (read_c && !write_c) begin
            count_nxt_c = count_q - CW'(1);
        end

        if (blocked_c && (ovr_q != SAT_MAX)) begin
            ovr_nxt_c = ovr_q + OVR_W'(1);
        end
    end

    // Pointers, count, strobe and counter state
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            rd_strobe_q <= 1'b0;
            ovr_q       <= '0;
        end else begin
            count_q     <= count_nxt_c;
            valid_q     <= (count_nxt_c != '0);
            rd_strobe_q <= write_c;
            ovr_q       <= ovr_nxt_c;
            if (bus.flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                // DEPTH is a power of two, so pointers wrap by overflow
                if (write_c) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (read_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    stereo_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (CLOCK_50),
        .we    (write_c),
        .waddr (wr_ptr_q),
        .wdata (wdata_c),
        .raddr (rd_ptr_q),
        .rdata (head_c)
    );

    assign bus.read_audio_in = rd_strobe_q;
    assign bus.sample_valid  = valid_q;
    assign bus.sample_L      = head_c.l;
    assign bus.sample_R      = head_c.r;
    assign bus.fill_level    = count_q;
    assign bus.overrun_cnt   = ovr_q;

endmodule

// File: tb/tb_audio_in_buffer.sv
// Bench for audio_in_buffer: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a queue-based model.
module tb_audio_in_buffer;
    import audio_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam logic [15:0] SAT   = 16'd10;

    logic CLOCK_50;
    logic reset_n;

    audio_in_buffer_if #(.DEPTH(DEPTH)) bus ();

    audio_in_buffer #(
        .DEPTH   (DEPTH),
        .SAT_MAX (SAT)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int total = 0;
    int bad   = 0;

    // Reference model: the FIFO is a queue, the strobe a remembered flag
    stereo_t mq[$];
    bit      m_rd;
    int      m_ovr;
    sample_t dut_pops[$];
    int      max_level;

    task automatic cmp(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_rd  = 1'b0;
        m_ovr = 0;
    endtask

    task automatic check_model();
        cmp("rd_strobe", longint'(bus.read_audio_in), longint'(m_rd));
        cmp("fill", longint'(bus.fill_level), longint'(mq.size()));
        cmp("valid", longint'(bus.sample_valid), longint'(mq.size() != 0));
        if (mq.size() != 0) begin
            cmp("head_L", longint'(bus.sample_L), longint'(mq[0].l));
            cmp("head_R", longint'(bus.sample_R), longint'(mq[0].r));
        end
        cmp("overrun", longint'(bus.overrun_cnt), longint'(m_ovr));
    endtask

    // One clock: observe DUT pops, advance the model, check after the edge
    task automatic step();
        int sz;
        bit wr, rdd, blk;
        if (bus.sample_valid && bus.sample_ready && !bus.flush)
            dut_pops.push_back(bus.sample_L);
        @(posedge CLOCK_50);
        sz = mq.size();
        if (bus.flush) begin
            mq.delete();
            m_rd = 1'b0;
        end else begin
            wr  = bus.audio_in_available && !m_rd && (sz < DEPTH);
            blk = bus.audio_in_available && !m_rd && (sz == DEPTH);
            rdd = (sz > 0) && bus.sample_ready;
            if (rdd) void'(mq.pop_front());
            if (wr)  mq.push_back('{l: bus.audio_in_L, r: bus.audio_in_R});
            m_rd = wr;
            if (blk && (m_ovr < int'(SAT))) m_ovr++;
        end
        #1;
        if (int'(bus.fill_level) > max_level) max_level = int'(bus.fill_level);
        check_model();
    endtask

    task automatic drive(input bit av, input logic [31:0] l, input logic [31:0] r,
                         input bit rdy, input bit fl);
        bus.audio_in_available = av;
        bus.audio_in_L         = l;
        bus.audio_in_R         = r;
        bus.sample_ready       = rdy;
        bus.flush              = fl;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        model_clear();
    endtask

    typedef struct {
        bit          av;
        logic [31:0] l;
        logic [31:0] r;
        bit          rdy;
        bit          fl;
        bit          e_rd;
        int          e_fill;
        bit          e_valid;
        logic [31:0] e_l;
        logic [31:0] e_r;
    } vec_t;

    vec_t vt[7];

    initial begin
        int strobes, nxt, ovr0;
        bit prev_rd, dbl;
        logic [31:0] head0;

        vt[0] = '{1, 32'h0000_1234, 32'hFFFF_EDCC, 0, 0, 1, 1, 1, 32'h0000_1234, 32'hFFFF_EDCC};
        vt[1] = '{0, 32'h0, 32'h0,                 0, 0, 0, 1, 1, 32'h0000_1234, 32'hFFFF_EDCC};
        vt[2] = '{0, 32'h0, 32'h0,                 1, 0, 0, 0, 0, 32'h0, 32'h0};
        vt[3] = '{1, 32'h0000_0011, 32'h0000_0022, 0, 0, 1, 1, 1, 32'h0000_0011, 32'h0000_0022};
        vt[4] = '{1, 32'h8000_0033, 32'h7FFF_FF44, 1, 0, 0, 0, 0, 32'h0, 32'h0};
        vt[5] = '{1, 32'h8000_0033, 32'h7FFF_FF44, 1, 0, 1, 1, 1, 32'h8000_0033, 32'h7FFF_FF44};
        vt[6] = '{1, 32'h0000_0055, 32'h0000_0066, 1, 1, 0, 0, 0, 32'h0, 32'h0};

        max_level = 0;
        do_reset();

        // Reset state
        cmp("reset_rd", longint'(bus.read_audio_in), 0);
        cmp("reset_fill", longint'(bus.fill_level), 0);
        cmp("reset_valid", longint'(bus.sample_valid), 0);
        cmp("reset_ovr", longint'(bus.overrun_cnt), 0);

        // Directed vector table
        foreach (vt[i]) begin
            drive(vt[i].av, vt[i].l, vt[i].r, vt[i].rdy, vt[i].fl);
            step();
            cmp($sformatf("vec%0d_rd", i), longint'(bus.read_audio_in), longint'(vt[i].e_rd));
            cmp($sformatf("vec%0d_fill", i), longint'(bus.fill_level), longint'(vt[i].e_fill));
            cmp($sformatf("vec%0d_valid", i), longint'(bus.sample_valid), longint'(vt[i].e_valid));
            if (vt[i].e_valid) begin
                cmp($sformatf("vec%0d_L", i), longint'(bus.sample_L), longint'(signed'(vt[i].e_l)));
                cmp($sformatf("vec%0d_R", i), longint'(bus.sample_R), longint'(signed'(vt[i].e_r)));
            end
        end

        // Simultaneous write and read at fill level 4
        nxt = 100;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'(nxt), 32'(-nxt), 1'b0, 1'b0);
            step();
            if (m_rd) nxt++;
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        cmp("simul_pre_fill", longint'(bus.fill_level), 4);
        head0 = bus.sample_L;
        drive(1'b1, 32'(nxt), 32'(-nxt), 1'b1, 1'b0);
        step();
        cmp("simul_fill", longint'(bus.fill_level), 4);
        cmp("simul_head", longint'(bus.sample_L), longint'(signed'(head0 + 32'd1)));
        cmp("simul_rd", longint'(bus.read_audio_in), 1);

        // Flush at fill level 5 with the codec still offering data
        nxt++;
        drive(1'b1, 32'(nxt), 32'(-nxt), 1'b0, 1'b0);
        step();
        step();
        cmp("flush_pre_fill", longint'(bus.fill_level), 5);
        ovr0 = int'(bus.overrun_cnt);
        drive(1'b1, 32'(nxt + 1), 32'd0, 1'b0, 1'b1);
        step();
        cmp("flush_fill", longint'(bus.fill_level), 0);
        cmp("flush_valid", longint'(bus.sample_valid), 0);
        cmp("flush_rd", longint'(bus.read_audio_in), 0);
        cmp("flush_ovr", longint'(bus.overrun_cnt), longint'(ovr0));

        // Fill to DEPTH with available held, then count overruns to saturation
        strobes = 0;
        prev_rd = 1'b0;
        dbl     = 1'b0;
        ovr0    = int'(bus.overrun_cnt);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'(200 + i), 32'(300 + i), 1'b0, 1'b0);
            step();
            if (bus.read_audio_in) strobes++;
            if (bus.read_audio_in && prev_rd) dbl = 1'b1;
            prev_rd = bus.read_audio_in;
        end
        cmp("fill_strobes", longint'(strobes), 8);
        cmp("fill_no_back2back", longint'(dbl), 0);
        cmp("fill_level_full", longint'(bus.fill_level), 8);
        cmp("fill_ovr", longint'(bus.overrun_cnt), longint'(ovr0 + 4));
        for (int i = 0; i < 10; i++) step();
        cmp("ovr_saturated", longint'(bus.overrun_cnt), longint'(SAT));

        // Asynchronous reset between edges while full
        #2;
        reset_n = 1'b0;
        #1;
        cmp("areset_fill", longint'(bus.fill_level), 0);
        cmp("areset_valid", longint'(bus.sample_valid), 0);
        cmp("areset_rd", longint'(bus.read_audio_in), 0);
        cmp("areset_ovr", longint'(bus.overrun_cnt), 0);
        do_reset();

        // Ordering: push 1..20 with ready toggling pseudo-randomly
        dut_pops.delete();
        max_level = 0;
        nxt = 1;
        for (int c = 0; c < 600 && dut_pops.size() < 20; c++) begin
            drive(nxt <= 20, 32'(nxt), ~32'(nxt), 1'($urandom_range(0, 1)), 1'b0);
            step();
            if (m_rd) nxt++;
        end
        cmp("order_count", longint'(dut_pops.size()), 20);
        for (int i = 0; i < dut_pops.size() && i < 20; i++)
            cmp($sformatf("order_%0d", i), longint'(dut_pops[i]), longint'(i + 1));
        cmp("order_max_level_ok", longint'(max_level <= int'(DEPTH)), 1);

        // Randomized run against the model
        for (int c = 0; c < 1500; c++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 39) == 0));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
